// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, timer width,
// and frame-length helper.
package uart_pkg;

   localparam int TIMER_W    = 19;
   localparam int FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2
   } state_t;

   // Bits following the start bit: data (7/8), optional parity, stop.
   function automatic logic [3:0] frame_len(input logic eight, input logic parity_en);
      return 4'd8 + {3'b000, eight} + {3'b000, parity_en};
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: pulses btu after half a bit (start check) or a full bit
// (data/stop), reloading to zero on each pulse.
module uart_bit_timer
   import uart_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               half,
   input  logic [TIMER_W-1:0] k,
   output logic               btu
);

   logic [TIMER_W-1:0] cnt;
   logic [TIMER_W-1:0] limit;

   always_comb begin
      limit = half ? (k >> 1) : k;
      btu   = run && (cnt == limit);
   end

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking (=) is reserved for always_comb.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!run || btu) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: start detect, mid-bit sampling, 7/8 data bits, optional
// parity, stop check; sticky ready/error flags for the host interface.
module uart_receive
   import uart_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               rx,
   input  logic               eight,
   input  logic               parity_en,
   input  logic               ohel,
   input  logic [TIMER_W-1:0] k,
   output logic [7:0]         data,
   output logic               RXRDY,
   output logic               PERR,
   output logic               FERR,
   output logic               OVF
);

   state_t          state;
   state_t          state_next;
   logic            btu;
   logic            done;
   logic [3:0]      bit_cnt;
   logic [3:0]      frame_n;
   logic [3:0]      shamt;
   logic [9:0]      shreg;
   logic [7:0]      aligned;
   logic [7:0]      rx_data;
   logic            stop_bit;
   logic            par_bit;
   logic            par_err;

   assign frame_n = frame_len(eight, parity_en);

   uart_bit_timer u_timer (
      .clk  (clk),
      .rst  (rst),
      .run  ((state == START) || (state == DATA)),
      .half (state == START),
      .k    (k),
      .btu  (btu)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      done       = 1'b0;
      case (state)
         IDLE:  if (!rx) state_next = START;
         START: if (btu) state_next = rx ? IDLE : DATA;
         DATA: begin
            // >= rather than == so a mid-frame format change cannot strand the FSM
            if (bit_cnt >= frame_n) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         shreg   <= '1;
      end else if (state == IDLE) begin
         bit_cnt <= '0;
      end else if ((state == DATA) && btu && !done) begin
         bit_cnt <= bit_cnt + 1'b1;
         shreg   <= {rx, shreg[9:1]};
      end
   end

   // Stop lands at shreg[9], parity at shreg[8]; shift data down to bit 0.
   always_comb begin
      shamt    = 4'(FRAME_BITS) - frame_n;
      aligned  = 8'(shreg >> shamt);
      rx_data  = eight ? aligned : {1'b0, aligned[6:0]};
      stop_bit = shreg[9];
      par_bit  = shreg[8];
      par_err  = parity_en && (par_bit != ((^rx_data) ^ ohel));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= '0;
         RXRDY <= 1'b0;
         PERR  <= 1'b0;
         FERR  <= 1'b0;
         OVF   <= 1'b0;
      end else if (done) begin
         data  <= rx_data;
         RXRDY <= 1'b1;
         OVF   <= OVF  | RXRDY;
         FERR  <= FERR | !stop_bit;
         PERR  <= PERR | par_err;
      end else if (clr) begin
         RXRDY <= 1'b0;
         PERR  <= 1'b0;
         FERR  <= 1'b0;
         OVF   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: frames are driven bit by bit in step with
// the receiver's btu pulse; results are compared against hand-computed values.
module tb_uart_receive;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        rx;
   logic        eight;
   logic        parity_en;
   logic        ohel;
   logic [18:0] k;
   logic [7:0]  data;
   logic        RXRDY;
   logic        PERR;
   logic        FERR;
   logic        OVF;

   int total    = 0;
   int bad      = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int lat;
   int dlt;
   int d_snap;

   uart_receive dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .rx        (rx),
      .eight     (eight),
      .parity_en (parity_en),
      .ohel      (ohel),
      .k         (k),
      .data      (data),
      .RXRDY     (RXRDY),
      .PERR      (PERR),
      .FERR      (FERR),
      .OVF       (OVF)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (dut.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_btu(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (dut.btu === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, "_btu_timeout"}, 32'(seen), 32'd1);
   endtask

   // bits[0] is the first bit after start; bits[n-1] is the stop bit.
   task automatic send_frame(input string tag, input logic [9:0] bits, input int n,
                             output int latency);
      int t0;
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1 rx = 1'b0;
      t0 = cyc;
      wait_btu(tag);
      @(posedge clk); #1 rx = bits[0];
      for (int i = 0; i < n; i++) begin
         wait_btu(tag);
         @(posedge clk); #1 rx = (i == n - 1) ? 1'b1 : bits[i + 1];
      end
      @(negedge clk);
      check({tag, "_done"}, 32'(dut.done), 32'd1);
      latency = cyc - t0;
      @(posedge clk); #1;
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; rx = 1'b1;
      eight = 1'b1; parity_en = 1'b1; ohel = 1'b0; k = 19'd108;
      #23;
      check("rst_data",  32'(data),  32'h00);
      check("rst_rxrdy", 32'(RXRDY), 32'd0);
      check("rst_perr",  32'(PERR),  32'd0);
      check("rst_ferr",  32'(FERR),  32'd0);
      check("rst_ovf",   32'(OVF),   32'd0);
      check("rst_state", 32'(dut.state == IDLE), 32'd1);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);

      // 8E1, 0xAE with wrong parity bit 0 (five ones need 1)
      send_frame("f1", 10'b1_0_10101110, 10, lat);
      check("f1_data",  32'(data),  32'hAE);
      check("f1_rxrdy", 32'(RXRDY), 32'd1);
      check("f1_perr",  32'(PERR),  32'd1);
      check("f1_ferr",  32'(FERR),  32'd0);
      check("f1_ovf",   32'(OVF),   32'd0);
      dlt = 2 * lat - 21 * 109;
      check("f1_latency", 32'(dlt >= -4 && dlt <= 4), 32'd1);
      pulse_clr();
      check("clr1_rxrdy", 32'(RXRDY), 32'd0);
      check("clr1_perr",  32'(PERR),  32'd0);

      // same byte, correct parity
      send_frame("f2", 10'b1_1_10101110, 10, lat);
      check("f2_data",  32'(data),  32'hAE);
      check("f2_perr",  32'(PERR),  32'd0);
      check("f2_rxrdy", 32'(RXRDY), 32'd1);
      check("f2_ovf",   32'(OVF),   32'd0);
      pulse_clr();
      check("clr2_rxrdy", 32'(RXRDY), 32'd0);

      // 7N1, 0x55
      eight = 1'b0; parity_en = 1'b0;
      send_frame("f3", 10'b00_1_1010101, 8, lat);
      check("f3_data",  32'(data),    32'h55);
      check("f3_bit7",  32'(data[7]), 32'd0);
      check("f3_rxrdy", 32'(RXRDY),   32'd1);
      check("f3_ferr",  32'(FERR),    32'd0);
      pulse_clr();

      // 8N1, 0x3C with stop bit 0
      eight = 1'b1;
      send_frame("f4", 10'b0_0_00111100, 9, lat);
      check("f4_data",  32'(data),  32'h3C);
      check("f4_ferr",  32'(FERR),  32'd1);
      check("f4_rxrdy", 32'(RXRDY), 32'd1);
      check("f4_ovf",   32'(OVF),   32'd0);

      // good frame without clr: FERR sticky, overrun
      send_frame("f5", 10'b0_1_10000001, 9, lat);
      check("f5_data", 32'(data), 32'h81);
      check("f5_ferr", 32'(FERR), 32'd1);
      check("f5_ovf",  32'(OVF),  32'd1);
      pulse_clr();
      check("clr5_ferr",  32'(FERR),  32'd0);
      check("clr5_ovf",   32'(OVF),   32'd0);
      check("clr5_rxrdy", 32'(RXRDY), 32'd0);

      // back-to-back pair
      send_frame("f6", 10'b0_1_01111110, 9, lat);
      check("f6_data", 32'(data), 32'h7E);
      check("f6_ovf",  32'(OVF),  32'd0);
      send_frame("f7", 10'b0_1_11000011, 9, lat);
      check("f7_data", 32'(data), 32'hC3);
      check("f7_ovf",  32'(OVF),  32'd1);
      check("f7_ferr", 32'(FERR), 32'd0);

      // glitch shorter than half a bit
      d_snap = done_cnt;
      @(posedge clk); #1 rx = 1'b0;
      repeat (20) @(posedge clk);
      #1 rx = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("glitch_done",  32'(done_cnt - d_snap), 32'd0);
      check("glitch_state", 32'(dut.state == IDLE), 32'd1);
      check("glitch_data",  32'(data),  32'hC3);
      check("glitch_rxrdy", 32'(RXRDY), 32'd1);
      check("glitch_ovf",   32'(OVF),   32'd1);
      check("glitch_perr",  32'(PERR),  32'd0);

      // reset in the middle of a frame
      d_snap = done_cnt;
      @(posedge clk); #1 rx = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      check("mid_state", 32'(dut.state == DATA), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_data",  32'(data),  32'h00);
      check("mid_rst_rxrdy", 32'(RXRDY), 32'd0);
      check("mid_rst_ovf",   32'(OVF),   32'd0);
      check("mid_rst_state", 32'(dut.state == IDLE), 32'd1);
      rx = 1'b1;
      @(negedge clk) rst = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("mid_rst_nodone", 32'(done_cnt - d_snap), 32'd0);
      check("mid_rst_rxrdy2", 32'(RXRDY), 32'd0);

      // recovery: 8O1, 0x01 with parity bit 0 (odd total)
      parity_en = 1'b1; ohel = 1'b1;
      send_frame("f8", 10'b1_0_00000001, 10, lat);
      check("f8_data",  32'(data),  32'h01);
      check("f8_perr",  32'(PERR),  32'd0);
      check("f8_rxrdy", 32'(RXRDY), 32'd1);
      check("f8_ovf",   32'(OVF),   32'd0);
      check("f8_ferr",  32'(FERR),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
